imem_loader: RTL and testbench

//  Boot-time writer for the cpu_top instruction memory. It is the hardware replacement for
//  the bench-side $readmemh load. It accepts 32-bit instruction words on a valid/ready stream
//  and writes them into consecutive IMEM word addresses starting at 0. It optionally pads the

---
 rtl/imem_loader_if.sv | 26 ++
 rtl/imem_loader.sv | 129 ++++++++++++
 tb/tb_imem_loader.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Instruction-stream input and IMEM write port of the boot-time IMEM loader.
// Latency: none (signal bundle only).
// Backpressure: s_ready comes from the loader; the imem_* write signals carry no backpressure.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  s_valid;
    logic                  s_ready;
    logic [31:0]           s_data;
    logic                  s_last;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_waddr;
    logic [31:0]           imem_wdata;

    // Loader side: consumes the stream and drives IMEM.
    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, imem_we, imem_waddr, imem_wdata
    );

    // Image source side: drives the stream and observes IMEM writes.
    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: streams an instruction image into IMEM from word 0, optionally pads it with NOPs, then releases the core.
// Latency: each write appears one cycle after its accept or fill step; cpu_reset falls RESET_HOLD cycles after the last write.
// Backpressure: s_ready is high only in LOAD and never depends on s_valid; FILL, HOLD, RUN and ERROR stall the stream.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int FILL_NOP   = 1,
    parameter int RESET_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset,
    imem_loader_if.slave        bus,
    input  logic                reload,
    output logic                cpu_reset,
    output logic                done,
    output logic                error,
    output logic [ADDR_WIDTH:0] word_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   WC_MAX    = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   WC_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [31:0]           NOP       = 32'h0000_0013;
    // The hold counter starts at RESET_HOLD-1 and RUN is entered on the cycle it reads 0,
    // which puts the cpu_reset fall exactly RESET_HOLD cycles after the last write cycle.
    localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(RESET_HOLD - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_FILL,
        S_HOLD,
        S_RUN,
        S_ERROR
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [HW-1:0]         hold_cnt;
    logic                  accept;

    // Ready is a pure state decode so the source can never create a combinational loop through it.
    assign bus.s_ready = (state == S_LOAD);
    assign accept      = bus.s_valid & bus.s_ready;

    // Load/fill/hold sequencer with registered IMEM write port and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_LOAD;
            ptr            <= '0;
            hold_cnt       <= '0;
            word_count     <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_waddr <= '0;
            bus.imem_wdata <= '0;
            cpu_reset      <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_waddr <= ptr;
                        bus.imem_wdata <= bus.s_data;
                        if (word_count != WC_MAX) begin
                            word_count <= word_count + WC_ONE;
                        end
                        if (ptr == LAST_ADDR) begin
                            // The top word is written either way; ptr stays put so address 0 is never overwritten.
                            if (bus.s_last) begin
                                state    <= S_HOLD;
                                hold_cnt <= HOLD_INIT;
                            end else begin
                                state <= S_ERROR;
                                error <= 1'b1;
                            end
                        end else begin
                            ptr <= ptr + PTR_ONE;
                            if (bus.s_last) begin
                                if (FILL_NOP != 0) begin
                                    state <= S_FILL;
                                end else begin
                                    state    <= S_HOLD;
                                    hold_cnt <= HOLD_INIT;
                                end
                            end
                        end
                    end
                end
                S_FILL: begin
                    bus.imem_we    <= 1'b1;
                    bus.imem_waddr <= ptr;
                    bus.imem_wdata <= NOP;
                    if (ptr == LAST_ADDR) begin
                        state    <= S_HOLD;
                        hold_cnt <= HOLD_INIT;
                    end else begin
                        ptr <= ptr + PTR_ONE;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == '0) begin
                        state     <= S_RUN;
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_ONE;
                    end
                end
                S_RUN, S_ERROR: begin
                    if (reload) begin
                        state      <= S_LOAD;
                        ptr        <= '0;
                        word_count <= '0;
                        cpu_reset  <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                    end
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of per-cycle vectors plus hand-written multi-cycle sequences.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: stream accepts follow the s_ready decode; a second instance covers the no-fill path.
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reload = 1'b0;
    logic       cpu_reset, done, error;
    logic [3:0] word_count;

    logic       reset_b = 1'b1;
    logic       reload_b = 1'b0;
    logic       cpu_reset_b, done_b, error_b;
    logic [3:0] word_count_b;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_WIDTH(3)) bus ();
    imem_loader_if #(.ADDR_WIDTH(3)) bus_b ();

    imem_loader #(.ADDR_WIDTH(3), .FILL_NOP(1), .RESET_HOLD(4)) dut (
        .clk(clk), .reset(reset), .bus(bus), .reload(reload),
        .cpu_reset(cpu_reset), .done(done), .error(error), .word_count(word_count)
    );

    imem_loader #(.ADDR_WIDTH(3), .FILL_NOP(0), .RESET_HOLD(1)) dut_b (
        .clk(clk), .reset(reset_b), .bus(bus_b), .reload(reload_b),
        .cpu_reset(cpu_reset_b), .done(done_b), .error(error_b), .word_count(word_count_b)
    );

    typedef struct packed {
        logic        rst;
        logic        vld;
        logic [31:0] dat;
        logic        lst;
        logic        rld;
    } in_t;

    typedef struct packed {
        logic        rdy;
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic        cr;
        logic        dn;
        logic        er;
        logic [3:0]  wc;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic v(input logic rst, input logic vld, input logic [31:0] dat, input logic lst,
                     input logic rld, input logic rdy, input logic we, input logic [2:0] addr,
                     input logic [31:0] wd, input logic cr, input logic dn, input logic er,
                     input logic [3:0] wc);
        vec_t x;
        x.i = '{rst: rst, vld: vld, dat: dat, lst: lst, rld: rld};
        x.o = '{rdy: rdy, we: we, addr: addr, wd: wd, cr: cr, dn: dn, er: er, wc: wc};
        vecs.push_back(x);
    endtask

    function automatic out_t sample_a();
        out_t s;
        s = {bus.s_ready, bus.imem_we, bus.imem_waddr, bus.imem_wdata,
             cpu_reset, done, error, word_count};
        return s;
    endfunction

    initial begin
        logic [31:0] img[3];
        logic        vp[6];
        int          n, fills, last_we, fall;

        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
        bus_b.s_valid = 1'b0; bus_b.s_data = '0; bus_b.s_last = 1'b0;
        img[0] = 32'h0050_0093; img[1] = 32'h00A0_0113; img[2] = 32'h0020_81B3;

        // ---------------- vector table (DUT A: depth 8, NOP fill, hold 4) ----------------
        v(1,0,32'h0,0,0,               1,0,0,32'h0,1,0,0,0);
        v(1,0,32'h0,0,0,               1,0,0,32'h0,1,0,0,0);
        v(1,1,32'hDEAD_0000,1,1,       1,0,0,32'h0,1,0,0,0);   // reset beats stream and reload
        v(0,1,img[0],0,0,              1,1,0,img[0],1,0,0,1);
        v(0,1,img[1],0,0,              1,1,1,img[1],1,0,0,2);
        v(0,1,img[2],1,0,              0,1,2,img[2],1,0,0,3);
        for (int a = 3; a <= 7; a++)   // stream offered during fill is ignored, reload too
            v(0,1,32'hBAD0_0000 | a,0,(a == 4), 0,1,3'(a),32'h13,1,0,0,3);
        for (int h = 0; h < 3; h++)
            v(0,0,32'h0,0,(h == 1),    0,0,7,32'h13,1,0,0,3);
        v(0,0,32'h0,0,0,               0,0,7,32'h13,0,1,0,3);  // 4 cycles after last write
        v(0,1,32'h7777_7777,0,0,       0,0,7,32'h13,0,1,0,3);
        v(0,0,32'h0,0,1,               1,0,7,32'h13,1,0,0,0);  // reload from RUN
        v(0,1,32'hDEAD_BEEF,0,0,       1,1,0,32'hDEAD_BEEF,1,0,0,1);
        v(0,1,32'hCAFE_0001,0,0,       1,1,1,32'hCAFE_0001,1,0,0,2);
        v(1,1,32'hCAFE_0002,0,0,       1,0,0,32'h0,1,0,0,0);   // reset mid-load
        for (int k = 0; k < 8; k++) begin
            if (k == 2) v(0,0,32'h9999,0,0, 1,0,1,32'h1001,1,0,0,2);
            v(0,1,32'h1000 + k,0,0,    (k != 7),1,3'(k),32'h1000 + k,1,0,(k == 7),4'(k + 1));
        end
        v(0,1,32'h1008,1,0,            0,0,7,32'h1007,1,0,1,8);  // 9th word refused
        v(0,0,32'h0,0,1,               1,0,7,32'h1007,1,0,0,0);  // reload from ERROR
        for (int k = 0; k < 8; k++)    // full-depth image: last at top word goes to HOLD
            v(0,1,32'h2000 + k,(k == 7),0, (k != 7),1,3'(k),32'h2000 + k,1,0,0,4'(k + 1));
        for (int h = 0; h < 3; h++)
            v(0,0,32'h0,0,0,           0,0,7,32'h2007,1,0,0,8);
        v(0,0,32'h0,0,0,               0,0,7,32'h2007,0,1,0,8);

        foreach (vecs[idx]) begin
            reset       = vecs[idx].i.rst;
            bus.s_valid = vecs[idx].i.vld;
            bus.s_data  = vecs[idx].i.dat;
            bus.s_last  = vecs[idx].i.lst;
            reload      = vecs[idx].i.rld;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", idx), 64'(sample_a()), 64'(vecs[idx].o));
        end
        reload = 1'b0;

        // ---------------- gapped image on DUT A ----------------
        reset = 1'b1; bus.s_valid = 1'b0; bus.s_last = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        vp[0] = 1; vp[1] = 0; vp[2] = 0; vp[3] = 1; vp[4] = 0; vp[5] = 1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            bus.s_valid = vp[c];
            bus.s_data  = vp[c] ? img[n] : 32'hFFFF_FFFF;
            bus.s_last  = vp[c] && (n == 2);
            @(posedge clk); #1;
            if (vp[c]) begin
                chk($sformatf("gap_wr%0d", c), {bus.imem_we, 5'(bus.imem_waddr), bus.imem_wdata},
                    {1'b1, 5'(n), img[n]});
                n++;
            end else begin
                chk($sformatf("gap_idle%0d", c), 64'(bus.imem_we), 64'(0));
            end
        end
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        fills = 0; last_we = -1; fall = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (bus.imem_we) begin
                chk($sformatf("fill%0d", fills), {5'(bus.imem_waddr), bus.imem_wdata},
                    {5'(fills + 3), 32'h13});
                fills++;
                last_we = cyc;
            end
            if (!cpu_reset) begin
                fall = cyc;
                break;
            end
        end
        chk("gap_release_seen", 64'(fall >= 0), 64'(1));
        chk("gap_fill_count", 64'(fills), 64'(5));
        chk("gap_hold_len", 64'(fall - last_we), 64'(4));
        chk("gap_status", {done, error, word_count}, {1'b1, 1'b0, 4'd3});

        // ---------------- DUT B: no fill, hold 1 ----------------
        @(posedge clk); #1;
        reset_b = 1'b0;
        bus_b.s_valid = 1'b1; bus_b.s_data = 32'hA5A5_0001; bus_b.s_last = 1'b0;
        @(posedge clk); #1;
        chk("b_wr0", {bus_b.s_ready, bus_b.imem_we, 5'(bus_b.imem_waddr), bus_b.imem_wdata},
            {1'b1, 1'b1, 5'd0, 32'hA5A5_0001});
        bus_b.s_data = 32'hA5A5_0002; bus_b.s_last = 1'b1;
        @(posedge clk); #1;
        chk("b_wr1", {bus_b.s_ready, bus_b.imem_we, 5'(bus_b.imem_waddr), cpu_reset_b},
            {1'b0, 1'b1, 5'd1, 1'b1});
        bus_b.s_valid = 1'b0; bus_b.s_last = 1'b0;
        @(posedge clk); #1;
        chk("b_release", {bus_b.imem_we, cpu_reset_b, done_b, error_b, word_count_b},
            {1'b0, 1'b0, 1'b1, 1'b0, 4'd2});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
